// File: rtl/regfile_sb.sv
// Parametrised register file with two write ports, same-cycle bypass and a
// per-register busy scoreboard for issue-time operand hazard detection.
module regfile_sb #(
    parameter int REG_SIZE = 32,
    parameter int REG_NUM  = 16,
    parameter int RD_PORTS = 2,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(REG_NUM)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         we0,
    input  logic [AW-1:0]                rd0,
    input  logic [REG_SIZE-1:0]          d0,
    input  logic                         we1,
    input  logic [AW-1:0]                rd1,
    input  logic [REG_SIZE-1:0]          d1,
    input  logic                         rsv_en,
    input  logic [AW-1:0]                rsv_idx,
    input  logic [RD_PORTS*AW-1:0]       rs,
    output logic [RD_PORTS*REG_SIZE-1:0] rv,
    output logic [RD_PORTS-1:0]          hz,
    output logic [REG_NUM-1:0]           busy,
    output logic [REG_NUM*REG_SIZE-1:0]  regs_out
);

    localparam bit BYP = (BYPASS != 0);

    logic [REG_SIZE-1:0] regs_q [REG_NUM];
    logic [REG_SIZE-1:0] regs_d [REG_NUM];
    logic [REG_NUM-1:0]  busy_q;
    logic [REG_NUM-1:0]  busy_d;

    // Port 1 overrides port 0; a reservation overrides a release because the
    // new producer is still in flight even though the old data lands.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int r = 1; r < REG_NUM; r++) begin
            if (we1 && (rd1 == AW'(r))) begin
                regs_d[r] = d1;
            end else if (we0 && (rd0 == AW'(r))) begin
                regs_d[r] = d0;
            end
            if (rsv_en && (rsv_idx == AW'(r))) begin
                busy_d[r] = 1'b1;
            end else if ((we0 && (rd0 == AW'(r))) ||
                         (we1 && (rd1 == AW'(r)))) begin
                busy_d[r] = 1'b0;
            end
        end
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
        logic [AW-1:0]       sel;
        logic                hit0;
        logic                hit1;
        logic [REG_SIZE-1:0] val;
        logic                haz;

        assign sel  = rs[i*AW +: AW];
        assign hit0 = we0 && (rd0 == sel);
        assign hit1 = we1 && (rd1 == sel);

        always_comb begin
            val = regs_q[sel];
            haz = busy_q[sel];
            if (sel == '0) begin
                val = '0;
                haz = 1'b0;
            end else if (BYP) begin
                if (hit1) begin
                    val = d1;
                end else if (hit0) begin
                    val = d0;
                end
                if (hit0 || hit1) begin
                    haz = 1'b0;
                end
            end
        end

        assign rv[i*REG_SIZE +: REG_SIZE] = val;
        assign hz[i]                      = haz;
    end

    for (genvar r = 0; r < REG_NUM; r++) begin : g_out
        assign regs_out[r*REG_SIZE +: REG_SIZE] = regs_q[r];
    end

    assign busy = busy_q;

endmodule
